// File: rtl/hdd_pkg.sv
// Shared definitions for the ProDOS HDD path: transfer states, sector buffer geometry
// and the command/status codes the HDD interface exchanges with the CPU.
package hdd_pkg;

    localparam int unsigned BLOCK_BYTES = 512;
    localparam int unsigned SECBUF_AW   = 9;

    localparam logic [7:0] PRODOS_CMD_STATUS = 8'h00;
    localparam logic [7:0] PRODOS_CMD_READ   = 8'h01;
    localparam logic [7:0] PRODOS_CMD_WRITE  = 8'h02;
    localparam logic [7:0] PRODOS_CMD_FORMAT = 8'h03;

    localparam logic [7:0] PRODOS_ST_OK       = 8'h00;
    localparam logic [7:0] PRODOS_ST_IO_ERR   = 8'h27;
    localparam logic [7:0] PRODOS_ST_NO_DEV   = 8'h28;
    localparam logic [7:0] PRODOS_ST_WR_PROT  = 8'h2B;

    typedef enum logic [2:0] {
        IDLE,
        REQ_RD,
        XFER_RD,
        REQ_WR,
        XFER_WR,
        FIN
    } hdd_xfer_state_t;

    // Byte counter stops at one full block so overruns never alias back to "complete".
    function automatic logic [9:0] sat_inc(input logic [9:0] c);
        return (c == 10'(BLOCK_BYTES)) ? c : c + 10'd1;
    endfunction

endpackage

// File: rtl/hdd_timeout_ctr.sv
// Clear/enable counter that pulses o_expire on the TIMEOUT-th enabled cycle.
// Shared with the floppy path.
module hdd_timeout_ctr #(
    parameter int unsigned TIMEOUT = 24'hFFFFFF
) (
    input  logic CLK_14M,
    input  logic RESET,
    input  logic i_clr,
    input  logic i_en,
    output logic o_expire
);

    localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    logic [CW-1:0] r_cnt;

    assign o_expire = i_en && (r_cnt == CW'(TIMEOUT - 1));

    always_ff @(posedge CLK_14M) begin
        if (RESET || i_clr) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= o_expire ? '0 : r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/hdd_sd_bridge.sv
// Moves one 512-byte block between the ProDOS HDD sector buffer and the host
// block-device channel, with busy/done handshake and a sticky error flag.
module hdd_sd_bridge
    import hdd_pkg::*;
#(
    parameter int unsigned BLK_W   = 16,
    parameter int unsigned TIMEOUT = 24'hFFFFFF
) (
    input  logic                 CLK_14M,
    input  logic                 RESET,
    input  logic                 hdd_read,
    input  logic                 hdd_write,
    input  logic [BLK_W-1:0]     sector,
    output logic [SECBUF_AW-1:0] ram_addr,
    output logic [7:0]           ram_di,
    output logic                 ram_we,
    input  logic [7:0]           ram_do,
    output logic [31:0]          sd_lba,
    output logic                 sd_rd,
    output logic                 sd_wr,
    input  logic                 sd_ack,
    input  logic [SECBUF_AW-1:0] sd_buff_addr,
    input  logic [7:0]           sd_buff_dout,
    input  logic                 sd_buff_wr,
    output logic [7:0]           sd_buff_din,
    output logic                 busy,
    output logic                 done,
    output logic                 error
);

    hdd_xfer_state_t      r_state;
    logic [9:0]           r_cnt;
    logic [SECBUF_AW-1:0] r_ram_addr;
    logic [SECBUF_AW-1:0] r_prev_addr;
    logic [7:0]           r_ram_di;
    logic                 r_ram_we;
    logic [31:0]          r_lba;
    logic                 r_sd_rd;
    logic                 r_sd_wr;
    logic                 r_busy;
    logic                 r_done;
    logic                 r_error;

    logic       w_accept;
    logic       w_tmo_en;
    logic       w_tmo_expire;
    logic [9:0] w_cnt_rd;
    logic [9:0] w_cnt_wr;

    assign w_accept = (r_state == IDLE) && (hdd_read || hdd_write);
    assign w_tmo_en = ((r_state == REQ_RD) || (r_state == REQ_WR)) && !sd_ack;
    assign w_cnt_rd = sd_buff_wr ? sat_inc(r_cnt) : r_cnt;
    assign w_cnt_wr = (sd_buff_addr != r_prev_addr) ? sat_inc(r_cnt) : r_cnt;

    hdd_timeout_ctr #(
        .TIMEOUT(TIMEOUT)
    ) u_tmo (
        .CLK_14M (CLK_14M),
        .RESET   (RESET),
        .i_clr   (w_accept),
        .i_en    (w_tmo_en),
        .o_expire(w_tmo_expire)
    );

    // Write direction: the buffer is addressed straight from the host so ram_do
    // lands one cycle after each address step.
    assign ram_addr    = (r_state == XFER_WR) ? sd_buff_addr :
                         (r_state == IDLE)    ? '0 : r_ram_addr;
    assign sd_buff_din = (r_state == XFER_WR) ? ram_do : 8'h00;
    assign ram_di      = r_ram_di;
    assign ram_we      = r_ram_we;
    assign sd_lba      = r_lba;
    assign sd_rd       = r_sd_rd;
    assign sd_wr       = r_sd_wr;
    assign busy        = r_busy;
    assign done        = r_done;
    assign error       = r_error;

    always_ff @(posedge CLK_14M) begin
        if (RESET) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_ram_addr  <= '0;
            r_prev_addr <= '0;
            r_ram_di    <= '0;
            r_ram_we    <= 1'b0;
            r_lba       <= '0;
            r_sd_rd     <= 1'b0;
            r_sd_wr     <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_error     <= 1'b0;
        end else begin
            r_ram_we <= 1'b0;
            r_done   <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_lba   <= 32'(sector);
                        r_error <= 1'b0;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                        if (hdd_read) begin
                            r_sd_rd <= 1'b1;
                            r_state <= REQ_RD;
                        end else begin
                            r_sd_wr <= 1'b1;
                            r_state <= REQ_WR;
                        end
                    end
                end
                REQ_RD, REQ_WR: begin
                    if (sd_ack) begin
                        r_sd_rd     <= 1'b0;
                        r_sd_wr     <= 1'b0;
                        r_prev_addr <= sd_buff_addr;
                        if (r_state == REQ_WR) begin
                            r_cnt   <= 10'd1;
                            r_state <= XFER_WR;
                        end else begin
                            r_state <= XFER_RD;
                        end
                    end else if (w_tmo_expire) begin
                        r_sd_rd <= 1'b0;
                        r_sd_wr <= 1'b0;
                        r_error <= 1'b1;
                        r_done  <= 1'b1;
                        r_state <= FIN;
                    end
                end
                XFER_RD: begin
                    // Strobes are honoured even on the ack-falling cycle.
                    r_ram_we <= sd_buff_wr;
                    if (sd_buff_wr) begin
                        r_ram_addr <= sd_buff_addr;
                        r_ram_di   <= sd_buff_dout;
                    end
                    r_cnt <= w_cnt_rd;
                    if (!sd_ack) begin
                        r_done  <= 1'b1;
                        r_state <= FIN;
                        if (w_cnt_rd != 10'(BLOCK_BYTES)) r_error <= 1'b1;
                    end
                end
                XFER_WR: begin
                    if (sd_ack) begin
                        r_prev_addr <= sd_buff_addr;
                        r_cnt       <= w_cnt_wr;
                    end else begin
                        r_done  <= 1'b1;
                        r_state <= FIN;
                        if (r_cnt != 10'(BLOCK_BYTES)) r_error <= 1'b1;
                    end
                end
                FIN: begin
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_hdd_sd_bridge.sv
// Directed bench for hdd_sd_bridge: read, write, timeout, short transfer,
// request collisions and reset in mid-transfer against a behavioural sector buffer.
module tb_hdd_sd_bridge;

    logic        CLK_14M = 1'b0;
    logic        RESET;
    logic        hdd_read;
    logic        hdd_write;
    logic [15:0] sector;
    logic [8:0]  ram_addr;
    logic [7:0]  ram_di;
    logic        ram_we;
    logic [7:0]  ram_do;
    logic [31:0] sd_lba;
    logic        sd_rd;
    logic        sd_wr;
    logic        sd_ack;
    logic [8:0]  sd_buff_addr;
    logic [7:0]  sd_buff_dout;
    logic        sd_buff_wr;
    logic [7:0]  sd_buff_din;
    logic        busy;
    logic        done;
    logic        error;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] mem [512];
    logic       preload = 1'b0;
    int         we_cnt   = 0;
    int         done_cnt = 0;
    int         wr_cnt   = 0;

    hdd_sd_bridge #(
        .BLK_W  (16),
        .TIMEOUT(16)
    ) dut (
        .CLK_14M     (CLK_14M),
        .RESET       (RESET),
        .hdd_read    (hdd_read),
        .hdd_write   (hdd_write),
        .sector      (sector),
        .ram_addr    (ram_addr),
        .ram_di      (ram_di),
        .ram_we      (ram_we),
        .ram_do      (ram_do),
        .sd_lba      (sd_lba),
        .sd_rd       (sd_rd),
        .sd_wr       (sd_wr),
        .sd_ack      (sd_ack),
        .sd_buff_addr(sd_buff_addr),
        .sd_buff_dout(sd_buff_dout),
        .sd_buff_wr  (sd_buff_wr),
        .sd_buff_din (sd_buff_din),
        .busy        (busy),
        .done        (done),
        .error       (error)
    );

    always #5 CLK_14M = ~CLK_14M;

    // Sector buffer with registered read, plus event counters.
    always @(posedge CLK_14M) begin
        ram_do <= mem[ram_addr];
        if (preload) begin
            for (int i = 0; i < 512; i++) mem[i] <= ~8'(i);
        end else if (ram_we) begin
            mem[ram_addr] <= ram_di;
        end
        if (ram_we) we_cnt <= we_cnt + 1;
        if (done)   done_cnt <= done_cnt + 1;
        if (sd_wr)  wr_cnt <= wr_cnt + 1;
    end

    task automatic tick();
        @(negedge CLK_14M);
    endtask

    task automatic pulse_req(input logic rd, input logic wr, input logic [15:0] sec);
        sector    = sec;
        hdd_read  = rd;
        hdd_write = wr;
        tick();
        hdd_read  = 1'b0;
        hdd_write = 1'b0;
    endtask

    task automatic start_ack();
        sd_ack = 1'b1;
        tick();
    endtask

    task automatic stream_rd(input int first, input int n);
        for (int i = first; i < first + n; i++) begin
            sd_buff_wr   = 1'b1;
            sd_buff_addr = 9'(i);
            sd_buff_dout = 8'(i);
            tick();
        end
        sd_buff_wr = 1'b0;
    endtask

    task automatic wait_idle(output bit ok);
        sd_ack = 1'b0;
        ok = 1'b0;
        for (int k = 0; k < 50; k++) begin
            tick();
            if (!busy) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        RESET = 1'b1;
        repeat (3) tick();
        n_tests++;
        if ({busy, done, error} !== 3'b000) begin
            n_fail++; $display("FAIL rst_flags: got %b want 000", {busy, done, error});
        end
        n_tests++;
        if ({sd_rd, sd_wr, ram_we} !== 3'b000) begin
            n_fail++; $display("FAIL rst_strobes: got %b want 000", {sd_rd, sd_wr, ram_we});
        end
        n_tests++;
        if (sd_lba !== 32'h0) begin
            n_fail++; $display("FAIL rst_lba: got %h want 00000000", sd_lba);
        end
        n_tests++;
        if ({ram_addr, sd_buff_din} !== 17'h0) begin
            n_fail++; $display("FAIL rst_addr_din: got %h/%h want 0/0", ram_addr, sd_buff_din);
        end
        RESET = 1'b0;
        tick();
    endtask

    task automatic test_stale_ack();
        sd_ack = 1'b1;
        repeat (4) tick();
        n_tests++;
        if ({busy, sd_rd, sd_wr} !== 3'b000) begin
            n_fail++; $display("FAIL stale_ack: got %b want 000", {busy, sd_rd, sd_wr});
        end
        sd_ack = 1'b0;
        tick();
    endtask

    task automatic test_read();
        int we0;
        int d0;
        bit ok;
        we0 = we_cnt;
        d0  = done_cnt;
        pulse_req(1'b1, 1'b0, 16'h0123);
        n_tests++;
        if ({busy, sd_rd, sd_wr} !== 3'b110) begin
            n_fail++; $display("FAIL rd_req: got %b want 110", {busy, sd_rd, sd_wr});
        end
        n_tests++;
        if (sd_lba !== 32'h0000_0123) begin
            n_fail++; $display("FAIL rd_lba: got %h want 00000123", sd_lba);
        end
        start_ack();
        n_tests++;
        if (sd_rd !== 1'b0) begin
            n_fail++; $display("FAIL rd_req_drop: got %b want 0", sd_rd);
        end
        stream_rd(0, 512);
        wait_idle(ok);
        n_tests++;
        if (!ok) begin
            n_fail++; $display("FAIL rd_idle: busy still %b want 0", busy);
        end
        n_tests++;
        if (we_cnt - we0 !== 512) begin
            n_fail++; $display("FAIL rd_we_cnt: got %0d want 512", we_cnt - we0);
        end
        n_tests++;
        if (mem[511] !== 8'hFF || mem[200] !== 8'hC8) begin
            n_fail++; $display("FAIL rd_data: got %h/%h want ff/c8", mem[511], mem[200]);
        end
        n_tests++;
        if (done_cnt - d0 !== 1) begin
            n_fail++; $display("FAIL rd_done: got %0d pulses want 1", done_cnt - d0);
        end
        n_tests++;
        if (error !== 1'b0) begin
            n_fail++; $display("FAIL rd_error: got %b want 0", error);
        end
    endtask

    task automatic test_write();
        int we0;
        int d0;
        int bad;
        bit ok;
        preload = 1'b1;
        tick();
        preload = 1'b0;
        we0 = we_cnt;
        d0  = done_cnt;
        pulse_req(1'b0, 1'b1, 16'h0042);
        n_tests++;
        if ({busy, sd_rd, sd_wr} !== 3'b101) begin
            n_fail++; $display("FAIL wr_req: got %b want 101", {busy, sd_rd, sd_wr});
        end
        n_tests++;
        if (sd_lba !== 32'h0000_0042) begin
            n_fail++; $display("FAIL wr_lba: got %h want 00000042", sd_lba);
        end
        sd_buff_addr = 9'd0;
        start_ack();
        bad = 0;
        for (int i = 0; i < 512; i++) begin
            sd_buff_addr = 9'(i);
            tick();
            if (sd_buff_din !== ~8'(i) || ram_addr !== 9'(i)) bad++;
            tick();
        end
        n_tests++;
        if (bad !== 0) begin
            n_fail++; $display("FAIL wr_din: got %0d bad bytes want 0", bad);
        end
        wait_idle(ok);
        n_tests++;
        if (!ok) begin
            n_fail++; $display("FAIL wr_idle: busy still %b want 0", busy);
        end
        n_tests++;
        if (we_cnt - we0 !== 0) begin
            n_fail++; $display("FAIL wr_no_we: got %0d pulses want 0", we_cnt - we0);
        end
        n_tests++;
        if (done_cnt - d0 !== 1 || error !== 1'b0) begin
            n_fail++; $display("FAIL wr_done: got %0d/%b want 1/0", done_cnt - d0, error);
        end
    endtask

    task automatic test_timeout();
        int d0;
        int hi;
        d0 = done_cnt;
        hi = 0;
        pulse_req(1'b1, 1'b0, 16'h0007);
        for (int k = 0; k < 40; k++) begin
            if (sd_rd) hi++;
            tick();
        end
        n_tests++;
        if (hi !== 16) begin
            n_fail++; $display("FAIL tmo_len: got %0d cycles want 16", hi);
        end
        n_tests++;
        if ({busy, error} !== 2'b01) begin
            n_fail++; $display("FAIL tmo_flags: got busy,err %b want 01", {busy, error});
        end
        n_tests++;
        if (done_cnt - d0 !== 1) begin
            n_fail++; $display("FAIL tmo_done: got %0d pulses want 1", done_cnt - d0);
        end
        pulse_req(1'b1, 1'b0, 16'h0008);
        n_tests++;
        if ({error, busy} !== 2'b01) begin
            n_fail++; $display("FAIL tmo_clear: got err,busy %b want 01", {error, busy});
        end
        repeat (30) tick();
        n_tests++;
        if ({busy, error} !== 2'b01) begin
            n_fail++; $display("FAIL tmo_again: got busy,err %b want 01", {busy, error});
        end
    endtask

    task automatic test_short();
        int we0;
        int d0;
        bit ok;
        we0 = we_cnt;
        d0  = done_cnt;
        pulse_req(1'b1, 1'b0, 16'h0010);
        start_ack();
        stream_rd(0, 300);
        wait_idle(ok);
        n_tests++;
        if (!ok || error !== 1'b1) begin
            n_fail++; $display("FAIL short_err: got ok=%b err=%b want 1/1", ok, error);
        end
        n_tests++;
        if (we_cnt - we0 !== 300) begin
            n_fail++; $display("FAIL short_we: got %0d want 300", we_cnt - we0);
        end
        n_tests++;
        if (done_cnt - d0 !== 1) begin
            n_fail++; $display("FAIL short_done: got %0d pulses want 1", done_cnt - d0);
        end
    endtask

    task automatic test_collision();
        int w0;
        int we0;
        bit ok;
        w0  = wr_cnt;
        we0 = we_cnt;
        pulse_req(1'b1, 1'b1, 16'h0005);
        n_tests++;
        if ({sd_rd, sd_wr} !== 2'b10) begin
            n_fail++; $display("FAIL col_both: got rd,wr %b want 10", {sd_rd, sd_wr});
        end
        start_ack();
        stream_rd(0, 10);
        hdd_write = 1'b1;
        tick();
        hdd_write = 1'b0;
        stream_rd(10, 502);
        wait_idle(ok);
        repeat (3) tick();
        n_tests++;
        if (wr_cnt - w0 !== 0) begin
            n_fail++; $display("FAIL col_no_wr: got %0d sd_wr cycles want 0", wr_cnt - w0);
        end
        n_tests++;
        if (!ok || error !== 1'b0 || we_cnt - we0 !== 512) begin
            n_fail++;
            $display("FAIL col_xfer: got ok=%b err=%b we=%0d want 1/0/512", ok, error,
                     we_cnt - we0);
        end
    endtask

    task automatic test_reset_mid();
        int d0;
        int we0;
        bit ok;
        pulse_req(1'b1, 1'b0, 16'h0009);
        start_ack();
        stream_rd(0, 100);
        d0 = done_cnt;
        RESET = 1'b1;
        tick();
        n_tests++;
        if ({sd_rd, sd_wr, ram_we, busy, done, error} !== 6'b0) begin
            n_fail++;
            $display("FAIL rstmid_out: got %b want 000000", {sd_rd, sd_wr, ram_we, busy, done, error});
        end
        RESET  = 1'b0;
        sd_ack = 1'b0;
        repeat (3) tick();
        n_tests++;
        if (done_cnt - d0 !== 0 || busy !== 1'b0) begin
            n_fail++; $display("FAIL rstmid_done: got %0d/%b want 0/0", done_cnt - d0, busy);
        end
        n_tests++;
        if (mem[50] !== 8'd50) begin
            n_fail++; $display("FAIL rstmid_keep: got %h want 32", mem[50]);
        end
        d0  = done_cnt;
        we0 = we_cnt;
        pulse_req(1'b1, 1'b0, 16'h000A);
        start_ack();
        stream_rd(0, 512);
        wait_idle(ok);
        n_tests++;
        if (!ok || error !== 1'b0 || done_cnt - d0 !== 1 || we_cnt - we0 !== 512) begin
            n_fail++;
            $display("FAIL rstmid_fresh: got ok=%b err=%b done=%0d we=%0d want 1/0/1/512", ok,
                     error, done_cnt - d0, we_cnt - we0);
        end
    endtask

    initial begin
        RESET        = 1'b1;
        hdd_read     = 1'b0;
        hdd_write    = 1'b0;
        sector       = 16'h0;
        sd_ack       = 1'b0;
        sd_buff_addr = 9'h0;
        sd_buff_dout = 8'h0;
        sd_buff_wr   = 1'b0;
        test_reset();
        test_stale_ack();
        test_read();
        test_write();
        test_timeout();
        test_short();
        test_collision();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
